// File: rtl/ps2_color_pkg.sv
// ----------------------------------------------------------------------------
// ps2_color_pkg
// Shared definitions for the PS/2 colour selector:
//   - PS/2 set-2 prefix bytes (extended 0xE0, break 0xF0)
//   - scan codes for the number-row keys 1..8 and the left/right arrows
//   - encoding of the prefix-decoder FSM states
// No ports; imported by ps2_digit_lut and ps2_color_select.
// ----------------------------------------------------------------------------
package ps2_color_pkg;

    // Prefix bytes that precede extended and break codes.
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Number-row keys 1..8 map onto colour indices 0..7.
    localparam logic [7:0] SC_KEY_1 = 8'h16;
    localparam logic [7:0] SC_KEY_2 = 8'h1E;
    localparam logic [7:0] SC_KEY_3 = 8'h26;
    localparam logic [7:0] SC_KEY_4 = 8'h25;
    localparam logic [7:0] SC_KEY_5 = 8'h2E;
    localparam logic [7:0] SC_KEY_6 = 8'h36;
    localparam logic [7:0] SC_KEY_7 = 8'h3D;
    localparam logic [7:0] SC_KEY_8 = 8'h3E;

    // Arrow keys arrive as extended (0xE0-prefixed) make codes.
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LEFT  = 8'h6B;

    // Prefix decoder states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // waiting for a make code or a prefix
        ST_BRK     = 2'd1,  // seen 0xF0: next byte is a released plain key
        ST_EXT     = 2'd2,  // seen 0xE0: next byte is an extended make code
        ST_EXT_BRK = 2'd3   // seen 0xE0 0xF0: next byte is a released extended key
    } ps2_state_t;

endpackage : ps2_color_pkg

// File: rtl/ps2_color_select_if.sv
// ----------------------------------------------------------------------------
// ps2_color_select_if
// Bundles the keyboard byte stream, the video blanking flag and the colour
// outputs of ps2_color_select.
//   ps2_code     [7:0]        received scan-code byte
//   ps2_valid                 one-clock strobe qualifying ps2_code
//   blank                     high outside the active video area
//   out_color    [COLOR_W-1:0] colour index driven to the pixel path
//   color_update              one-clock pulse following an out_color change
// Modports: master = keyboard/video side (drives inputs), slave = selector.
// ----------------------------------------------------------------------------
interface ps2_color_select_if #(
    parameter int COLOR_W = 3
);
    logic [7:0]         ps2_code;
    logic               ps2_valid;
    logic               blank;
    logic [COLOR_W-1:0] out_color;
    logic               color_update;

    modport master (
        output ps2_code,
        output ps2_valid,
        output blank,
        input  out_color,
        input  color_update
    );

    modport slave (
        input  ps2_code,
        input  ps2_valid,
        input  blank,
        output out_color,
        output color_update
    );
endinterface : ps2_color_select_if

// File: rtl/ps2_digit_lut.sv
// ----------------------------------------------------------------------------
// ps2_digit_lut
// Purely combinational lookup from a plain scan code to a colour index for
// the number-row keys 1..8.
//   i_code   [7:0]  scan-code byte
//   o_hit           1 when i_code is one of the keys 1..8
//   o_index  [2:0]  colour index 0..7 for that key (0 when o_hit is 0)
// ----------------------------------------------------------------------------
module ps2_digit_lut
    import ps2_color_pkg::*;
(
    input  logic [7:0] i_code,
    output logic       o_hit,
    output logic [2:0] o_index
);

    always_comb begin
        // NOTE: every output gets a default before the case so that codes
        // outside the table cannot leave a path unassigned and infer a latch.
        o_hit   = 1'b1;
        o_index = 3'd0;
        case (i_code)
            SC_KEY_1: o_index = 3'd0;
            SC_KEY_2: o_index = 3'd1;
            SC_KEY_3: o_index = 3'd2;
            SC_KEY_4: o_index = 3'd3;
            SC_KEY_5: o_index = 3'd4;
            SC_KEY_6: o_index = 3'd5;
            SC_KEY_7: o_index = 3'd6;
            SC_KEY_8: o_index = 3'd7;
            default:  o_hit   = 1'b0;
        endcase
    end

endmodule : ps2_digit_lut

// File: rtl/ps2_color_select.sv
// ----------------------------------------------------------------------------
// ps2_color_select
// Decodes PS/2 set-2 scan codes into a colour selection and applies it to the
// pixel path only during blanking, so a colour never changes mid-line.
//   - keys 1..8 select colour index 0..7 directly (indices >= NUM_COLORS are
//     ignored)
//   - right/left arrow step the selection up/down, wrapping modulo NUM_COLORS
//   - break codes (0xF0 ...) and unknown codes are consumed without effect
//   - a prefix left hanging for TIMEOUT_CYC idle clocks is abandoned
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   bus (slave)   ps2_code/ps2_valid/blank in, out_color/color_update out
// Parameters:
//   COLOR_W       width of the colour index
//   NUM_COLORS    number of selectable colours, 2..2**COLOR_W
//   RESET_COLOR   colour loaded at reset, < NUM_COLORS
//   TIMEOUT_CYC   idle clocks after which a pending prefix is dropped
// Reset release is expected to be synchronised by the integrating top level.
// ----------------------------------------------------------------------------
module ps2_color_select
    import ps2_color_pkg::*;
#(
    parameter int COLOR_W     = 3,
    parameter int NUM_COLORS  = 8,
    parameter int RESET_COLOR = 0,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             reset,
    ps2_color_select_if.slave bus
);

    localparam logic [COLOR_W-1:0] C_RESET   = COLOR_W'(RESET_COLOR);
    localparam logic [COLOR_W-1:0] C_LAST    = COLOR_W'(NUM_COLORS - 1);
    localparam logic [COLOR_W-1:0] C_ONE     = COLOR_W'(1);
    localparam logic [31:0]        C_TO_LAST = 32'(TIMEOUT_CYC - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ps2_state_t         r_state;
    logic [COLOR_W-1:0] r_pending;      // latest selection from the keyboard
    logic [COLOR_W-1:0] r_out_color;    // selection currently on the pixel path
    logic               r_color_update;
    logic [31:0]        r_idle_cnt;     // clocks since the last byte while a prefix is open

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               w_hit;
    logic [2:0]         w_index;
    logic               w_digit_ok;
    logic [COLOR_W-1:0] w_digit_color;
    logic [COLOR_W-1:0] w_pend_inc;
    logic [COLOR_W-1:0] w_pend_dec;
    logic               w_load;

    ps2_digit_lut u_digit_lut (
        .i_code  (bus.ps2_code),
        .o_hit   (w_hit),
        .o_index (w_index)
    );

    // Keys beyond the configured palette are treated like any unknown key.
    assign w_digit_ok    = w_hit && (int'(w_index) < NUM_COLORS);
    assign w_digit_color = COLOR_W'(w_index);

    // Wrap against NUM_COLORS explicitly; a non-power-of-two palette must not
    // fall through the natural 2**COLOR_W rollover.
    assign w_pend_inc = (r_pending == C_LAST)  ? '0     : r_pending + C_ONE;
    assign w_pend_dec = (r_pending == '0)      ? C_LAST : r_pending - C_ONE;

    // The pixel path only picks up a new colour while blanked.
    assign w_load = bus.blank && (r_pending != r_out_color);

    // ------------------------------------------------------------------
    // Prefix FSM, pending selection, blank-gated output and idle timeout
    // ------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments, so every term on
    // the right-hand side is the value from before the edge. That is what
    // makes a blank-load coinciding with a new keypress copy the old pending
    // and leave the new one for a later blank edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_pending      <= C_RESET;
            r_out_color    <= C_RESET;
            r_color_update <= 1'b0;
            r_idle_cnt     <= '0;
        end else begin
            // color_update is high for exactly the cycle in which the new
            // out_color value is first presented.
            r_color_update <= w_load;
            if (w_load) begin
                r_out_color <= r_pending;
            end

            if (bus.ps2_valid) begin
                r_idle_cnt <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (bus.ps2_code == SC_BRK) begin
                            r_state <= ST_BRK;
                        end else if (bus.ps2_code == SC_EXT) begin
                            r_state <= ST_EXT;
                        end else if (w_digit_ok) begin
                            r_pending <= w_digit_color;
                        end
                    end
                    ST_EXT: begin
                        if (bus.ps2_code == SC_BRK) begin
                            r_state <= ST_EXT_BRK;
                        end else if (bus.ps2_code == SC_EXT) begin
                            // Repeated 0xE0 keeps the extended prefix open.
                            r_state <= ST_EXT;
                        end else begin
                            r_state <= ST_IDLE;
                            if (bus.ps2_code == SC_RIGHT) begin
                                r_pending <= w_pend_inc;
                            end else if (bus.ps2_code == SC_LEFT) begin
                                r_pending <= w_pend_dec;
                            end
                        end
                    end
                    // The byte after a break prefix names a released key;
                    // releases never change the selection.
                    ST_BRK, ST_EXT_BRK: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end else if (r_state == ST_IDLE) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt == C_TO_LAST) begin
                // A prefix without its follow-up byte (lost byte, unplugged
                // keyboard) would otherwise misinterpret the next keypress.
                r_state    <= ST_IDLE;
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 32'd1;
            end
        end
    end

    assign bus.out_color    = r_out_color;
    assign bus.color_update = r_color_update;

endmodule : ps2_color_select

// File: tb/tb_ps2_color_select.sv
// ----------------------------------------------------------------------------
// tb_ps2_color_select
// Directed bench for ps2_color_select. Two instances share clk/reset:
//   dut_a : 8 colours, reset colour 0, timeout 16 clocks
//   dut_b : 6 colours, reset colour 3, timeout 16 clocks (wrap behaviour)
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ps2_color_select;

    logic clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;
    int upd_a_cnt = 0;   // color_update high cycles seen on dut_a
    int upd_b_cnt = 0;

    always #5 clk = ~clk;

    ps2_color_select_if #(.COLOR_W(3)) bus_a ();
    ps2_color_select_if #(.COLOR_W(3)) bus_b ();

    ps2_color_select #(
        .COLOR_W     (3),
        .NUM_COLORS  (8),
        .RESET_COLOR (0),
        .TIMEOUT_CYC (16)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    ps2_color_select #(
        .COLOR_W     (3),
        .NUM_COLORS  (6),
        .RESET_COLOR (3),
        .TIMEOUT_CYC (16)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Advance to the next falling edge and tally visible update pulses.
    task automatic tick();
        @(negedge clk);
        if (bus_a.color_update === 1'b1) upd_a_cnt++;
        if (bus_b.color_update === 1'b1) upd_b_cnt++;
    endtask

    task automatic send_a(input logic [7:0] code);
        bus_a.ps2_code  = code;
        bus_a.ps2_valid = 1'b1;
        tick();
        bus_a.ps2_valid = 1'b0;
        bus_a.ps2_code  = 8'h00;
    endtask

    task automatic send_b(input logic [7:0] code);
        bus_b.ps2_code  = code;
        bus_b.ps2_valid = 1'b1;
        tick();
        bus_b.ps2_valid = 1'b0;
        bus_b.ps2_code  = 8'h00;
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        bus_a.ps2_code  = 8'h00;
        bus_a.ps2_valid = 1'b0;
        bus_a.blank     = 1'b0;
        bus_b.ps2_code  = 8'h00;
        bus_b.ps2_valid = 1'b0;
        bus_b.blank     = 1'b1;
        repeat (2) tick();
        checks++;
        if (bus_a.out_color !== 3'd0) begin
            failures++; $display("FAIL reset_out_a got=%0d exp=0", bus_a.out_color);
        end
        checks++;
        if (bus_a.color_update !== 1'b0) begin
            failures++; $display("FAIL reset_upd_a got=%b exp=0", bus_a.color_update);
        end
        checks++;
        if (bus_b.out_color !== 3'd3) begin
            failures++; $display("FAIL reset_out_b got=%0d exp=3", bus_b.out_color);
        end
        checks++;
        if (bus_b.color_update !== 1'b0) begin
            failures++; $display("FAIL reset_upd_b got=%b exp=0", bus_b.color_update);
        end
        reset = 1'b1;
        tick();
        upd_a_cnt = 0;
        upd_b_cnt = 0;
    endtask

    // Key 3 while active video: held until blank, then one update pulse.
    task automatic test_digit_select();
        int c0;
        c0 = upd_a_cnt;
        bus_a.blank = 1'b0;
        send_a(8'h26);
        repeat (3) tick();
        checks++;
        if (bus_a.out_color !== 3'd0 || bus_a.color_update !== 1'b0) begin
            failures++; $display("FAIL digit_hold got=%0d/%b exp=0/0", bus_a.out_color, bus_a.color_update);
        end
        bus_a.blank = 1'b1;
        tick();
        checks++;
        if (bus_a.out_color !== 3'd2 || bus_a.color_update !== 1'b1) begin
            failures++; $display("FAIL digit_load got=%0d/%b exp=2/1", bus_a.out_color, bus_a.color_update);
        end
        tick();
        checks++;
        if (bus_a.out_color !== 3'd2 || bus_a.color_update !== 1'b0) begin
            failures++; $display("FAIL digit_after got=%0d/%b exp=2/0", bus_a.out_color, bus_a.color_update);
        end
        checks++;
        if (upd_a_cnt - c0 !== 1) begin
            failures++; $display("FAIL digit_pulses got=%0d exp=1", upd_a_cnt - c0);
        end
    endtask

    // Releases, extended releases and unknown keys leave the colour alone.
    task automatic test_break_ignore();
        int c0;
        c0 = upd_a_cnt;
        send_a(8'hF0); send_a(8'h16);
        send_a(8'hE0); send_a(8'hF0); send_a(8'h74);
        send_a(8'hE0); send_a(8'hE0); send_a(8'hF0); send_a(8'h6B);
        send_a(8'h1C);
        repeat (2) tick();
        checks++;
        if (bus_a.out_color !== 3'd2) begin
            failures++; $display("FAIL break_out got=%0d exp=2", bus_a.out_color);
        end
        checks++;
        if (upd_a_cnt - c0 !== 0) begin
            failures++; $display("FAIL break_pulses got=%0d exp=0", upd_a_cnt - c0);
        end
        // Decoder must be back in IDLE: key 4 now takes effect.
        send_a(8'h25);
        tick();
        checks++;
        if (bus_a.out_color !== 3'd3) begin
            failures++; $display("FAIL break_recover got=%0d exp=3", bus_a.out_color);
        end
    endtask

    // 16 idle clocks abandon the E0 prefix; 14 do not.
    task automatic test_timeout();
        send_a(8'hE0);
        repeat (16) tick();
        send_a(8'h74);
        repeat (2) tick();
        checks++;
        if (bus_a.out_color !== 3'd3) begin
            failures++; $display("FAIL timeout_expired got=%0d exp=3", bus_a.out_color);
        end
        send_a(8'hE0);
        repeat (14) tick();
        send_a(8'h74);
        repeat (2) tick();
        checks++;
        if (bus_a.out_color !== 3'd4) begin
            failures++; $display("FAIL timeout_open got=%0d exp=4", bus_a.out_color);
        end
    endtask

    // Key 7 lands on the same edge that blank-loads pending=1.
    task automatic test_collision();
        int c0;
        bus_a.blank = 1'b0;
        send_a(8'h1E);
        tick();
        c0 = upd_a_cnt;
        bus_a.ps2_code  = 8'h3D;
        bus_a.ps2_valid = 1'b1;
        bus_a.blank     = 1'b1;
        tick();
        bus_a.ps2_code  = 8'h00;
        bus_a.ps2_valid = 1'b0;
        bus_a.blank     = 1'b0;
        checks++;
        if (bus_a.out_color !== 3'd1 || bus_a.color_update !== 1'b1) begin
            failures++; $display("FAIL collide_first got=%0d/%b exp=1/1", bus_a.out_color, bus_a.color_update);
        end
        tick();
        checks++;
        if (bus_a.out_color !== 3'd1 || bus_a.color_update !== 1'b0) begin
            failures++; $display("FAIL collide_gap got=%0d/%b exp=1/0", bus_a.out_color, bus_a.color_update);
        end
        bus_a.blank = 1'b1;
        tick();
        checks++;
        if (bus_a.out_color !== 3'd6 || bus_a.color_update !== 1'b1) begin
            failures++; $display("FAIL collide_second got=%0d/%b exp=6/1", bus_a.out_color, bus_a.color_update);
        end
        tick();
        checks++;
        if (upd_a_cnt - c0 !== 2 || bus_a.color_update !== 1'b0) begin
            failures++; $display("FAIL collide_pulses got=%0d/%b exp=2/0", upd_a_cnt - c0, bus_a.color_update);
        end
    endtask

    // Six-colour instance: arrows wrap at 5<->0, keys 7/8 are out of range.
    task automatic test_wrap();
        send_b(8'h36);
        tick();
        checks++;
        if (bus_b.out_color !== 3'd5) begin
            failures++; $display("FAIL wrap_setup got=%0d exp=5", bus_b.out_color);
        end
        send_b(8'hE0); send_b(8'h74);
        tick();
        checks++;
        if (bus_b.out_color !== 3'd0 || bus_b.color_update !== 1'b1) begin
            failures++; $display("FAIL wrap_right got=%0d/%b exp=0/1", bus_b.out_color, bus_b.color_update);
        end
        send_b(8'hE0); send_b(8'h6B);
        tick();
        checks++;
        if (bus_b.out_color !== 3'd5) begin
            failures++; $display("FAIL wrap_left got=%0d exp=5", bus_b.out_color);
        end
        send_b(8'hE0); send_b(8'h6B);
        tick();
        checks++;
        if (bus_b.out_color !== 3'd4) begin
            failures++; $display("FAIL wrap_left2 got=%0d exp=4", bus_b.out_color);
        end
        send_b(8'h3D); send_b(8'h3E);
        repeat (2) tick();
        checks++;
        if (bus_b.out_color !== 3'd4) begin
            failures++; $display("FAIL wrap_range got=%0d exp=4", bus_b.out_color);
        end
        send_b(8'h16);
        tick();
        checks++;
        if (bus_b.out_color !== 3'd0) begin
            failures++; $display("FAIL wrap_key1 got=%0d exp=0", bus_b.out_color);
        end
    endtask

    // Asynchronous reset between edges after an E0 prefix.
    task automatic test_reset_midop();
        int c0;
        bus_a.blank = 1'b1;
        send_a(8'hE0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus_a.out_color !== 3'd0 || bus_a.color_update !== 1'b0) begin
            failures++; $display("FAIL midrst_a got=%0d/%b exp=0/0", bus_a.out_color, bus_a.color_update);
        end
        checks++;
        if (bus_b.out_color !== 3'd3) begin
            failures++; $display("FAIL midrst_b got=%0d exp=3", bus_b.out_color);
        end
        #1 reset = 1'b1;
        tick();
        c0 = upd_a_cnt;
        send_a(8'h74);
        repeat (2) tick();
        checks++;
        if (bus_a.out_color !== 3'd0 || upd_a_cnt - c0 !== 0) begin
            failures++; $display("FAIL midrst_prefix got=%0d/%0d exp=0/0", bus_a.out_color, upd_a_cnt - c0);
        end
        send_a(8'h25);
        tick();
        checks++;
        if (bus_a.out_color !== 3'd3) begin
            failures++; $display("FAIL midrst_after got=%0d exp=3", bus_a.out_color);
        end
    endtask

    initial begin
        test_reset();
        test_digit_select();
        test_break_ignore();
        test_timeout();
        test_collision();
        test_wrap();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ps2_color_select

// File: doc/ps2_color_select.md
PS2_COLOR_SELECT -- requirements
Module: ps2_color_select

Interface
REQ-001 SHALL have parameter COLOR_W, default 3, width of the colour index.
REQ-002 SHALL have parameter NUM_COLORS, default 8, number of selectable colours; legal range 2..2**COLOR_W.
REQ-003 SHALL have parameter RESET_COLOR, default 0, colour index loaded at reset; must be < NUM_COLORS.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 50000, number of idle clocks after which a pending prefix is abandoned.
REQ-005 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port ps2_code, input, 8, received PS/2 scan-code byte.
REQ-008 SHALL have port ps2_valid, input, 1, one-clock strobe qualifying ps2_code.
REQ-009 SHALL have port blank, input, 1, high while the VGA timing is outside the active video area.
REQ-010 SHALL have port out_color, output, COLOR_W, current colour index driven to the pixel path.
REQ-011 SHALL have port color_update, output, 1, one-clock pulse on the cycle after out_color changes.

Function
REQ-012 SHALL decode bytes with a 4-state FSM: IDLE, BRK (after 0xF0), EXT (after 0xE0), EXT_BRK (after 0xE0 0xF0).
REQ-013 Transitions SHALL occur only on ps2_valid=1. In IDLE: 0xF0->BRK; 0xE0->EXT; any other byte is a make code, evaluated, stay IDLE.
REQ-014 In EXT: 0xF0->EXT_BRK; 0xE0->stay EXT; any other byte is an extended make code, evaluated, ->IDLE.
REQ-015 In BRK and EXT_BRK, any byte SHALL be consumed without effect and the FSM SHALL return to IDLE.
REQ-016 Make codes 0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E (keys 1..8) SHALL set pending to index 0..7; indices >= NUM_COLORS and all other plain codes SHALL be ignored.
REQ-017 Extended make 0x74 (right arrow) SHALL set pending to pending+1, wrapping NUM_COLORS-1 -> 0.
REQ-018 Extended make 0x6B (left arrow) SHALL set pending to pending-1, wrapping 0 -> NUM_COLORS-1; other extended codes are ignored.
REQ-019 Wrap arithmetic SHALL be modulo NUM_COLORS, not modulo 2**COLOR_W.
REQ-020 Typematic repeats (make codes with no intervening break) SHALL each be evaluated.
REQ-021 pending SHALL update on the clock edge that samples the qualifying ps2_valid.
REQ-022 On each edge with blank=1 and pending!=out_color, out_color SHALL load pending. out_color SHALL never change while blank=0.
REQ-023 color_update SHALL be 1 exactly on the cycle following an out_color change, else 0.
REQ-024 When a pending update and a blank-load occur on the same edge, out_color SHALL take the old pending and the new pending SHALL be applied on a later blank edge.
REQ-025 A 32-bit-max idle counter SHALL run in BRK, EXT and EXT_BRK, clear on every ps2_valid, and force IDLE when it reaches TIMEOUT_CYC-1 with no byte; in IDLE it SHALL be held at 0.

Reset
REQ-026 Asserting reset (low) SHALL immediately force: FSM=IDLE, pending=RESET_COLOR, out_color=RESET_COLOR, color_update=0, idle counter=0.
REQ-027 Reset asserted mid-sequence (e.g. after 0xE0) SHALL discard the prefix; the first byte after release is decoded from IDLE.
REQ-028 Release SHALL be synchronous to clk via the integrating top level; the block itself performs no reset synchronisation.

Structure
REQ-029 Package ps2_color_pkg SHALL hold the prefix constants (0xE0, 0xF0), the key-1..8 and arrow scan-code constants, and the FSM state encoding.
REQ-030 Sub-module ps2_digit_lut SHALL be purely combinational: scan code -> {hit, 3-bit index}; all sequential logic stays in ps2_color_select.

Verification
REQ-031 Digit select: blank=0, send 0x26 -> pending=2 and out_color holds 0; raise blank -> out_color=2 on the next edge and color_update pulses once.
REQ-032 Wrap: NUM_COLORS=6, out_color=5, send E0 74 with blank=1 -> out_color=0; then E0 6B twice -> out_color=4.
REQ-033 Break and ignore: send F0 26, then E0 F0 74, then 0x1C, all with blank=1 -> out_color unchanged, no color_update pulse.
REQ-034 Prefix timeout: TIMEOUT_CYC=16, send E0, wait 16 idle clocks, send 0x74 -> treated as plain code, ignored; out_color unchanged.
REQ-035 Reset mid-op: send E0, pulse reset low asynchronously between edges -> out_color=RESET_COLOR immediately; after release, 0x74 has no effect.
REQ-036 Collision: a 0x3D strobe on the same edge as a blank-load of pending=1 -> out_color=1, then out_color=6 on the next blank edge, with two separate color_update pulses.
